word_deserializer: RTL and testbench

Serial-to-parallel word assembler. It is the write-side counterpart of the 32:1 bit selector: where the selector reads bit[sel] out of a word, this block writes each incoming bit into position[idx] of a word, with idx driven by an internal counter. Completed words leave through a valid/ready output register, and a one-word pending buffer absorbs backpressure. The block sits between a serial link front-end and the 32-bit datapath.

---
 rtl/word_deserializer.sv | 137 +++++++++++++
 tb/tb_word_deserializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/word_deserializer.sv
// Serial-to-parallel word assembler with a one-word pending buffer behind a valid/ready output.
// Optional WORD_DESER_PARITY_EN adds out_parity, the registered XOR of out_word.
module word_deserializer #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = 5,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [IDX_W:0]   out_count
`ifdef WORD_DESER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [IDX_W:0]   pcount_q, pcount_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic [IDX_W:0]   out_count_q, out_count_d;

    logic             accept;
    logic             xfer;
    logic             complete;
    logic [IDX_W-1:0] pos;
    logic [WIDTH-1:0] word_new;
    logic [IDX_W:0]   count_new;

    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid_q & out_ready;
    assign complete  = accept & ((idx_q == IDX_MAX) | in_last);
    assign pos       = (MSB_FIRST != 0) ? (IDX_MAX - idx_q) : idx_q;
    assign word_new  = asm_q | ({{(WIDTH-1){1'b0}}, in_bit} << pos);
    assign count_new = {1'b0, idx_q} + (IDX_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        pcount_d    = pcount_q;
        out_word_d  = out_word_q;
        out_count_d = out_count_q;
        // A transfer empties the output unless something reloads it below.
        out_valid_d = xfer ? 1'b0 : out_valid_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (complete) begin
                        idx_d = '0;
                        if (!out_valid_q || out_ready) begin
                            out_word_d  = word_new;
                            out_count_d = count_new;
                            out_valid_d = 1'b1;
                            asm_d       = '0;
                        end else begin
                            // Hold the finished word in place until the output frees up.
                            asm_d    = word_new;
                            pcount_d = count_new;
                            state_d  = PEND;
                        end
                    end else begin
                        asm_d = word_new;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PEND: begin
                if (xfer) begin
                    out_word_d  = asm_q;
                    out_count_d = pcount_q;
                    out_valid_d = 1'b1;
                    asm_d       = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            asm_q       <= '0;
            pcount_q    <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            pcount_q    <= pcount_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_count = out_count_q;

`ifdef WORD_DESER_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = ^out_word_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: LSB-first and MSB-first instances share one stimulus.
// Parity checks are built only when WORD_DESER_PARITY_EN is defined.
module tb_word_deserializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_bit;
    logic        in_last;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_word0, out_word1;
    logic [5:0]  out_count0, out_count1;
`ifdef WORD_DESER_PARITY_EN
    logic        out_parity0, out_parity1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    word_deserializer #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(0)) u_lsb (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_word  (out_word0),
        .out_count (out_count0)
`ifdef WORD_DESER_PARITY_EN
        ,
        .out_parity(out_parity0)
`endif
    );

    word_deserializer #(.WIDTH(32), .IDX_W(5), .MSB_FIRST(1)) u_msb (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_word  (out_word1),
        .out_count (out_count1)
`ifdef WORD_DESER_PARITY_EN
        ,
        .out_parity(out_parity1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b, input logic last);
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends n bits of w, LSB first; returns whether in_ready was high before every beat.
    task automatic send_word(input logic [31:0] w, input int n,
                             input logic last_on_n, output logic rdy_ok);
        rdy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!in_ready0) rdy_ok = 1'b0;
            beat(w[i], last_on_n && (i == n - 1));
        end
    endtask

    logic ok;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;

        check_eq("rst_valid", {31'd0, out_valid0}, 32'd0);
        check_eq("rst_word", out_word0, 32'd0);
        check_eq("rst_count", {26'd0, out_count0}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready0}, 32'd1);
`ifdef WORD_DESER_PARITY_EN
        check_eq("rst_parity", {31'd0, out_parity0}, 32'd0);
`endif

        // Full word, back to back.
        send_word(32'hDEADBEEF, 32, 1'b0, ok);
        check_eq("t1_ready_all", {31'd0, ok}, 32'd1);
        check_eq("t1_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t1_word", out_word0, 32'hDEADBEEF);
        check_eq("t1_count", {26'd0, out_count0}, 32'd32);
        check_eq("t1_msb_word", out_word1, 32'hF77DB57B);
        tick();
        check_eq("t1_valid_drop", {31'd0, out_valid0}, 32'd0);
        check_eq("t1_word_hold", out_word0, 32'hDEADBEEF);

        // Partial word then full word.
        send_word(32'h000000A5, 8, 1'b1, ok);
        check_eq("t2_word", out_word0, 32'h000000A5);
        check_eq("t2_count", {26'd0, out_count0}, 32'd8);
        check_eq("t2_msb_word", out_word1, 32'hA5000000);
        send_word(32'h12345678, 32, 1'b0, ok);
        check_eq("t2_full_word", out_word0, 32'h12345678);
        check_eq("t2_full_count", {26'd0, out_count0}, 32'd32);

        // Backpressure fills the pending buffer.
        tick();
        out_ready = 1'b0;
        send_word(32'h11111111, 32, 1'b0, ok);
        check_eq("t3_w1_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t3_w1_word", out_word0, 32'h11111111);
        send_word(32'h22222222, 32, 1'b0, ok);
        check_eq("t3_w2_ready_all", {31'd0, ok}, 32'd1);
        check_eq("t3_pend_ready", {31'd0, in_ready0}, 32'd0);
        tick();
        tick();
        check_eq("t3_stall_word", out_word0, 32'h11111111);
        check_eq("t3_stall_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t3_stall_ready", {31'd0, in_ready0}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t3_w2_word", out_word0, 32'h22222222);
        check_eq("t3_w2_valid", {31'd0, out_valid0}, 32'd1);
        check_eq("t3_w2_count", {26'd0, out_count0}, 32'd32);
        check_eq("t3_ready_back", {31'd0, in_ready0}, 32'd1);
        tick();
        check_eq("t3_w2_hold", out_word0, 32'h22222222);
        out_ready = 1'b1;
        tick();
        check_eq("t3_drain", {31'd0, out_valid0}, 32'd0);

        // MSB-first placement.
        send_word(32'h80000001, 32, 1'b0, ok);
        check_eq("t4_msb_word", out_word1, 32'h80000001);
        check_eq("t4_lsb_word", out_word0, 32'h80000001);
        send_word(32'h00000005, 3, 1'b1, ok);
        check_eq("t4_msb_short", out_word1, 32'hA0000000);
        check_eq("t4_msb_count", {26'd0, out_count1}, 32'd3);
        check_eq("t4_lsb_short", out_word0, 32'h00000005);

        // Reset mid-word discards the partial word.
        tick();
        send_word(32'h000003FF, 10, 1'b0, ok);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("t5_valid", {31'd0, out_valid0}, 32'd0);
        check_eq("t5_count", {26'd0, out_count0}, 32'd0);
        check_eq("t5_word", out_word0, 32'd0);
        check_eq("t5_ready", {31'd0, in_ready0}, 32'd1);
        send_word(32'hCAFEF00D, 32, 1'b0, ok);
        check_eq("t5_word_new", out_word0, 32'hCAFEF00D);
        check_eq("t5_count_new", {26'd0, out_count0}, 32'd32);

        // Single-bit word via in_last on the first bit.
        send_word(32'h00000001, 1, 1'b1, ok);
        check_eq("t7_one_word", out_word0, 32'h00000001);
        check_eq("t7_one_count", {26'd0, out_count0}, 32'd1);
        check_eq("t7_msb_one", out_word1, 32'h80000000);

`ifdef WORD_DESER_PARITY_EN
        send_word(32'h00000007, 3, 1'b1, ok);
        check_eq("t6_par7", {31'd0, out_parity0}, 32'd1);
        send_word(32'h00000003, 2, 1'b1, ok);
        check_eq("t6_par3", {31'd0, out_parity0}, 32'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
